// File: rtl/j1_io_pkg.sv
// Shared definitions for the J1 I/O arbiter: FSM encoding, parameter
// defaults and the latched request record.
package j1_io_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int unsigned TIMEOUT_CYC_DEFAULT = 16;
    localparam logic [15:0] ERR_DATA_DEFAULT    = 16'hDEAD;

    // Request fields captured from the winning master at grant time.
    typedef struct packed {
        logic        we;
        logic [11:0] addr;
        logic [15:0] wdata;
    } io_req_t;

endpackage

// File: rtl/j1_rr_arb2.sv
// Two-way round-robin grant logic. Under contention the master that was
// not served last wins; last_grant comes out of reset as 1 so m0 wins the
// first contention.
module j1_rr_arb2
    import j1_io_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req0_i,
    input  logic req1_i,
    input  logic upd_i,
    input  logic upd_idx_i,
    output logic gnt_valid_o,
    output logic gnt_idx_o
);

    logic last_grant_q;
    logic last_grant_d;

    // Pick the winner from the live requests and the last served index.
    always_comb begin
        gnt_valid_o  = req0_i | req1_i;
        gnt_idx_o    = 1'b0;
        last_grant_d = last_grant_q;
        if (req0_i && req1_i) begin
            gnt_idx_o = ~last_grant_q;
        end else begin
            gnt_idx_o = req1_i;
        end
        if (upd_i) begin
            last_grant_d = upd_idx_i;
        end
    end

    // Remember which master was served most recently.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/j1_io_arb.sv
// Two-master to one-slave I/O bus arbiter with slave-ack timeout.
//
// Handshake: a master raises req with we/addr/wdata valid and holds it until
// it sees its one-cycle ack; rdata and err are valid only while ack is high.
// Toward the slave, s_cyc/s_we/s_addr/s_wdata are held stable until s_ack,
// which is sampled only while a slave cycle is active.
module j1_io_arb
    import j1_io_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
    parameter logic [15:0] ERR_DATA    = ERR_DATA_DEFAULT
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [11:0] m0_addr,
    input  logic [15:0] m0_wdata,
    output logic        m0_ack,
    output logic [15:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [11:0] m1_addr,
    input  logic [15:0] m1_wdata,
    output logic        m1_ack,
    output logic [15:0] m1_rdata,
    output logic        m1_err,
    output logic        s_cyc,
    output logic        s_we,
    output logic [11:0] s_addr,
    output logic [15:0] s_wdata,
    input  logic [15:0] s_rdata,
    input  logic        s_ack,
    output logic        owner,
    output logic [1:0]  dbg_state_o
);

    // Last counter value before the timeout fires.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    logic [1:0]  state_q, state_d;
    io_req_t     req_q, req_d;
    logic        s_cyc_q, s_cyc_d;
    logic        owner_q, owner_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic        m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
    logic        m0_err_q, m0_err_d, m1_err_q, m1_err_d;
    logic [15:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;

    logic        gnt_valid;
    logic        gnt_idx;
    logic        upd;

    j1_rr_arb2 u_arb (
        .clk_i       (sys_clk_i),
        .rst_ni      (sys_rst_i),
        .req0_i      (m0_req),
        .req1_i      (m1_req),
        .upd_i       (upd),
        .upd_idx_i   (owner_q),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    // Next-state logic: grant in IDLE, wait for ack or timeout in BUSY,
    // deliver the response to the owner in RESP.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        s_cyc_d    = s_cyc_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        m0_ack_d   = 1'b0;
        m1_ack_d   = 1'b0;
        m0_err_d   = 1'b0;
        m1_err_d   = 1'b0;
        upd        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    req_d   = gnt_idx ? '{we: m1_we, addr: m1_addr, wdata: m1_wdata}
                                      : '{we: m0_we, addr: m0_addr, wdata: m0_wdata};
                    owner_d = gnt_idx;
                    s_cyc_d = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A slave ack in the final cycle still beats the timeout.
                if (s_ack) begin
                    rsp_data_d = s_rdata;
                    rsp_err_d  = 1'b0;
                    s_cyc_d    = 1'b0;
                    state_d    = ST_RESP;
                end else if (cnt_q == TO_LAST) begin
                    rsp_data_d = ERR_DATA;
                    rsp_err_d  = 1'b1;
                    s_cyc_d    = 1'b0;
                    state_d    = ST_RESP;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                if (owner_q) begin
                    m1_ack_d   = 1'b1;
                    m1_err_d   = rsp_err_q;
                    m1_rdata_d = rsp_data_q;
                end else begin
                    m0_ack_d   = 1'b1;
                    m0_err_d   = rsp_err_q;
                    m0_rdata_d = rsp_data_q;
                end
                upd     = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                s_cyc_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            s_cyc_q    <= 1'b0;
            owner_q    <= 1'b0;
            cnt_q      <= 8'd0;
            rsp_data_q <= 16'd0;
            rsp_err_q  <= 1'b0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m0_err_q   <= 1'b0;
            m1_err_q   <= 1'b0;
            m0_rdata_q <= 16'd0;
            m1_rdata_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            s_cyc_q    <= s_cyc_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            m0_ack_q   <= m0_ack_d;
            m1_ack_q   <= m1_ack_d;
            m0_err_q   <= m0_err_d;
            m1_err_q   <= m1_err_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    assign s_cyc       = s_cyc_q;
    assign s_we        = s_cyc_q & req_q.we;
    assign s_addr      = req_q.addr;
    assign s_wdata     = req_q.wdata;
    assign owner       = owner_q;
    assign m0_ack      = m0_ack_q;
    assign m1_ack      = m1_ack_q;
    assign m0_err      = m0_err_q;
    assign m1_err      = m1_err_q;
    assign m0_rdata    = m0_rdata_q;
    assign m1_rdata    = m1_rdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/j1_io_arb.md
J1_IO_ARB -- requirements
Module: j1_io_arb

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16, giving the slave-ack timeout in cycles (legal range 2..255).
REQ-002 SHALL have parameter ERR_DATA, default 16'hDEAD, giving the read data returned on a timeout.
REQ-003 SHALL have port sys_clk_i  in  1  single clock; all logic is on its rising edge.
REQ-004 SHALL have port sys_rst_i  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have port m0_req, m1_req  in  1 each  access request; held high until the matching ack.
REQ-006 SHALL have port m0_we, m1_we  in  1 each  1 = write, 0 = read; valid while req is high.
REQ-007 SHALL have port m0_addr, m1_addr  in  12 each  I/O address.
REQ-008 SHALL have port m0_wdata, m1_wdata  in  16 each  write data.
REQ-009 SHALL have port m0_ack, m1_ack  out  1 each  one-cycle completion pulse.
REQ-010 SHALL have port m0_rdata, m1_rdata  out  16 each  read data, valid in the cycle ack is high.
REQ-011 SHALL have port m0_err, m1_err  out  1 each  timeout flag, valid with ack.
REQ-012 SHALL have port s_cyc  out  1  slave cycle active.
REQ-013 SHALL have port s_we  out  1  slave write enable.
REQ-014 SHALL have port s_addr  out  12  slave address.
REQ-015 SHALL have port s_wdata  out  16  slave write data.
REQ-016 SHALL have port s_rdata  in  16  slave read data.
REQ-017 SHALL have port s_ack  in  1  slave completion.
REQ-018 SHALL have port owner  out  1  index of the granted master (debug).

Function
REQ-019 SHALL implement FSM states IDLE, BUSY and RESP.
REQ-020 IDLE: if any req is high, SHALL latch the winner's we/addr/wdata into registers, set owner, assert s_cyc next cycle, clear the timeout counter, and go to BUSY.
REQ-021 Arbitration SHALL be round-robin: with both req high, the master not granted last wins; last_grant resets to 1, so m0 wins the first contention.
REQ-022 BUSY: s_cyc, s_we, s_addr and s_wdata SHALL be driven from the latched registers and held stable.
REQ-023 BUSY: on s_ack, SHALL capture s_rdata, drop s_cyc, and go to RESP.
REQ-024 BUSY: when the counter reaches TIMEOUT_CYC-1 without s_ack, SHALL load ERR_DATA, set err, drop s_cyc, and go to RESP.
REQ-025 If s_ack and the timeout fall in the same cycle, s_ack SHALL win (no err).
REQ-026 RESP: SHALL pulse the owner's ack for exactly one cycle with rdata and err, update last_grant, and return to IDLE.
REQ-027 Throughput SHALL be at most one transaction per 3 cycles; the minimum latency from req to ack is 3 cycles with a zero-wait slave.
REQ-028 The non-owner's ack and err SHALL stay 0; its rdata SHALL hold its last value.
REQ-029 A requester that drops req mid-transaction SHALL NOT abort it; the transaction completes and acks normally.
REQ-030 s_ack received outside BUSY SHALL be ignored.
REQ-031 The timeout counter SHALL be 8 bits and SHALL NOT wrap; it saturates and is cleared on every grant.

Reset
REQ-032 Reset assertion SHALL asynchronously force IDLE; s_cyc, s_we, all acks and all errs to 0; s_addr, s_wdata and all rdata to 0; owner to 0; last_grant to 1; counter to 0.
REQ-033 Reset mid-BUSY SHALL abandon the transaction with no ack issued; the requester re-requests after reset.

Structure
REQ-034 A shared package j1_io_pkg SHALL hold the FSM state encoding and the defaults for TIMEOUT_CYC and ERR_DATA.
REQ-035 A single sub-module j1_rr_arb2 SHALL hold the 2-way round-robin grant logic and the last_grant register.

Verification
REQ-036 Scenario: m0 reads addr 12'h010, slave acks 1 cycle after s_cyc with 16'h0014 -> m0_ack pulses once, m0_rdata=16'h0014, m0_err=0.
REQ-037 Scenario: m0 and m1 request in the same cycle after reset -> m0 is served first, then m1; owner sequence 0,1.
REQ-038 Scenario: m1 writes 16'hBEEF to addr 12'h7FF -> s_we=1, s_addr=12'h7FF, s_wdata=16'hBEEF stable until s_ack.
REQ-039 Scenario: slave never acks -> s_cyc drops after 16 cycles; m0_ack=1, m0_err=1, m0_rdata=16'hDEAD.
REQ-040 Scenario: s_ack coincides with the final timeout cycle -> err=0 and the slave data is returned.
REQ-041 Scenario: sys_rst_i driven low mid-BUSY -> s_cyc=0 immediately and no ack is issued; the next request is granted normally.
